// File: rtl/tri_fetch_sched.sv
// Frame walker: per instance fetches record + descriptors, per triangle fetches
// the index triple and three vertices, then hands one assembled triangle downstream.
module tri_fetch_sched #(
  parameter int MAX_VERT     = 8192,
  parameter int MAX_TRI      = 8192,
  parameter int MAX_INST     = 256,
  parameter int MAX_VERT_CNT = 4096,
  parameter int MAX_TRI_CNT  = 4096,
  parameter int VTX_W        = 108,
  parameter int TRANS_W      = 384,
  localparam int VA_W   = $clog2(MAX_VERT),
  localparam int TA_W   = $clog2(MAX_TRI),
  localparam int IA_W   = $clog2(MAX_INST),
  localparam int VIDX_W = $clog2(MAX_VERT_CNT),
  localparam int TIDX_W = $clog2(MAX_TRI_CNT)
) (
  input  logic                clk,
  input  logic                rst_render,
  input  logic                start,
  input  logic                abort,
  input  logic [IA_W:0]       num_inst,
  input  logic                mem_ready,
  output logic [IA_W-1:0]     inst_id_rd,
  output logic                capture_inst,
  output logic [TA_W-1:0]     tri_addr_rd,
  output logic [VA_W-1:0]     vert_addr_rd,
  input  logic [TRANS_W-1:0]  transform_in,
  input  logic [VA_W-1:0]     vbase_in,
  input  logic [VIDX_W-1:0]   vcount_in,
  input  logic [TA_W-1:0]     tbase_in,
  input  logic [TIDX_W-1:0]   tcount_in,
  input  logic [3*VIDX_W-1:0] idx_tri_in,
  input  logic [VTX_W-1:0]    vert_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [VTX_W-1:0]    out_v0,
  output logic [VTX_W-1:0]    out_v1,
  output logic [VTX_W-1:0]    out_v2,
  output logic [TRANS_W-1:0]  out_xform,
  output logic [IA_W-1:0]     out_inst,
  output logic                busy,
  output logic                frame_done,
  output logic                idx_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_INST_RD, S_CAPTURE, S_DESC_W0, S_DESC_W1, S_TRI_RD, S_TRI_W,
    S_VRD0, S_VRD1, S_VRD2, S_VRD3, S_OUT, S_NEXT_INST, S_DONE
  } state_t;

  typedef struct packed {
    logic [VIDX_W-1:0] i0;
    logic [VIDX_W-1:0] i1;
    logic [VIDX_W-1:0] i2;
  } idx_t;

  state_t              state, state_n;
  idx_t                idx_in;
  logic [IA_W:0]       num_q;
  logic [IA_W-1:0]     inst_ctr;
  logic [TIDX_W-1:0]   tri_ctr;
  logic [VA_W-1:0]     vbase_q;
  logic [VIDX_W-1:0]   vcount_q;
  logic [TA_W-1:0]     tbase_q;
  logic [TIDX_W-1:0]   tcount_q;
  logic [VIDX_W-1:0]   i1_q, i2_q;
  logic [TIDX_W:0]     tri_inc;
  logic [IA_W:0]       inst_inc;
  logic                tri_last, inst_last, accept;

  assign idx_in    = idx_tri_in;
  assign accept    = start && mem_ready;
  // Extra MSB keeps the "ctr < count-1" tests exact at full-scale counts.
  assign tri_inc   = {1'b0, tri_ctr} + (TIDX_W+1)'(1);
  assign inst_inc  = {1'b0, inst_ctr} + (IA_W+1)'(1);
  assign tri_last  = tri_inc >= {1'b0, tcount_q};
  assign inst_last = inst_inc >= num_q;

  assign inst_id_rd   = inst_ctr;
  assign out_inst     = inst_ctr;
  assign tri_addr_rd  = tbase_q + TA_W'(tri_ctr);
  assign busy         = state != S_IDLE;
  // Strobes are masked by abort so a same-cycle abort never completes a handshake.
  assign out_valid    = (state == S_OUT) && !abort;
  assign capture_inst = (state == S_CAPTURE) && !abort;
  assign frame_done   = (state == S_DONE) && !abort;

  always_ff @(posedge clk) begin
    if (rst_render) state <= S_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (accept) state_n = (num_inst == '0) ? S_DONE : S_INST_RD;
      S_INST_RD:   state_n = S_CAPTURE;
      S_CAPTURE:   state_n = S_DESC_W0;
      S_DESC_W0:   state_n = S_DESC_W1;
      S_DESC_W1:   state_n = (tcount_in == '0) ? S_NEXT_INST : S_TRI_RD;
      S_TRI_RD:    state_n = S_TRI_W;
      S_TRI_W:     state_n = S_VRD0;
      S_VRD0:      state_n = S_VRD1;
      S_VRD1:      state_n = S_VRD2;
      S_VRD2:      state_n = S_VRD3;
      S_VRD3:      state_n = S_OUT;
      S_OUT:       if (out_ready) state_n = tri_last ? S_NEXT_INST : S_TRI_RD;
      S_NEXT_INST: state_n = inst_last ? S_DONE : S_INST_RD;
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst_render) begin
      num_q        <= '0;
      inst_ctr     <= '0;
      tri_ctr      <= '0;
      vbase_q      <= '0;
      vcount_q     <= '0;
      tbase_q      <= '0;
      tcount_q     <= '0;
      i1_q         <= '0;
      i2_q         <= '0;
      vert_addr_rd <= '0;
      out_v0       <= '0;
      out_v1       <= '0;
      out_v2       <= '0;
      out_xform    <= '0;
      idx_err      <= 1'b0;
    end else if (!abort) begin
      case (state)
        S_IDLE: if (accept) begin
          num_q    <= num_inst;
          inst_ctr <= '0;
          idx_err  <= 1'b0;
        end
        S_CAPTURE: out_xform <= transform_in;
        S_DESC_W1: begin
          vbase_q  <= vbase_in;
          vcount_q <= vcount_in;
          tbase_q  <= tbase_in;
          tcount_q <= tcount_in;
          tri_ctr  <= '0;
        end
        // Vertex address is registered one state early so it is live during VRDn.
        S_TRI_W: begin
          i1_q         <= idx_in.i1;
          i2_q         <= idx_in.i2;
          vert_addr_rd <= vbase_q + VA_W'(idx_in.i0);
          if (idx_in.i0 >= vcount_q || idx_in.i1 >= vcount_q || idx_in.i2 >= vcount_q)
            idx_err <= 1'b1;
        end
        S_VRD0: vert_addr_rd <= vbase_q + VA_W'(i1_q);
        S_VRD1: begin
          vert_addr_rd <= vbase_q + VA_W'(i2_q);
          out_v0       <= vert_in;
        end
        S_VRD2: out_v1 <= vert_in;
        S_VRD3: out_v2 <= vert_in;
        S_OUT: if (out_ready) tri_ctr <= tri_ctr + TIDX_W'(1);
        S_NEXT_INST: inst_ctr <= inst_ctr + IA_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_fetch_sched.sv
// Randomised scoreboard bench for tri_fetch_sched with a behavioural raster_mem model.
module tb_tri_fetch_sched;
  localparam int VA_W = 13, TA_W = 13, IA_W = 8, VIDX_W = 12, TIDX_W = 12;
  localparam int VTX_W = 108, TRANS_W = 384;

  logic                clk, rst_render, start, abort, mem_ready, out_ready;
  logic [IA_W:0]       num_inst;
  logic [IA_W-1:0]     inst_id_rd, out_inst;
  logic                capture_inst, out_valid, busy, frame_done, idx_err;
  logic [TA_W-1:0]     tri_addr_rd;
  logic [VA_W-1:0]     vert_addr_rd;
  logic [TRANS_W-1:0]  transform_in, out_xform;
  logic [VA_W-1:0]     vbase_in;
  logic [VIDX_W-1:0]   vcount_in;
  logic [TA_W-1:0]     tbase_in;
  logic [TIDX_W-1:0]   tcount_in;
  logic [3*VIDX_W-1:0] idx_tri_in;
  logic [VTX_W-1:0]    vert_in, out_v0, out_v1, out_v2;

  tri_fetch_sched dut (
    .clk(clk), .rst_render(rst_render), .start(start), .abort(abort), .num_inst(num_inst),
    .mem_ready(mem_ready), .inst_id_rd(inst_id_rd), .capture_inst(capture_inst),
    .tri_addr_rd(tri_addr_rd), .vert_addr_rd(vert_addr_rd), .transform_in(transform_in),
    .vbase_in(vbase_in), .vcount_in(vcount_in), .tbase_in(tbase_in), .tcount_in(tcount_in),
    .idx_tri_in(idx_tri_in), .vert_in(vert_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2), .out_xform(out_xform),
    .out_inst(out_inst), .busy(busy), .frame_done(frame_done), .idx_err(idx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // raster_mem model: vertex/transform contents are pure functions of the address
  logic [VA_W-1:0]     vb_arr [256];
  logic [VIDX_W-1:0]   vc_arr [256];
  logic [TA_W-1:0]     tb_arr [256];
  logic [TIDX_W-1:0]   tc_arr [256];
  logic [3*VIDX_W-1:0] tri_mem [8192];
  logic [IA_W-1:0]     cap_id;

  function automatic logic [VTX_W-1:0] vdata(input logic [VA_W-1:0] a);
    int ai;
    ai = int'(a);
    return {a, 32'(ai * 32'h9E3779B9), 32'(ai ^ 32'h5A5A1234), 31'(~ai)};
  endfunction

  function automatic logic [TRANS_W-1:0] xfdata(input logic [IA_W-1:0] i);
    logic [TRANS_W-1:0] r;
    for (int k = 0; k < 12; k++) r[k*32 +: 32] = 32'(int'(i) * 1000 + k);
    return r;
  endfunction

  always @(posedge clk) begin
    transform_in <= xfdata(inst_id_rd);
    if (capture_inst) cap_id <= inst_id_rd;
    vbase_in   <= vb_arr[cap_id];
    vcount_in  <= vc_arr[cap_id];
    tbase_in   <= tb_arr[cap_id];
    tcount_in  <= tc_arr[cap_id];
    idx_tri_in <= tri_mem[tri_addr_rd];
    vert_in    <= vdata(vert_addr_rd);
  end

  typedef struct {
    logic [VTX_W-1:0]   v0, v1, v2;
    logic [TRANS_W-1:0] xf;
    logic [IA_W-1:0]    inst;
  } beat_t;

  beat_t exp_q [$];
  int    checks = 0, errors = 0;
  int    fd_cnt = 0, cap_cnt = 0, fd0, cap0, exp_n;
  bit    exp_err;
  int    rdy_mode = 0;
  bit    rdy_man = 1'b0;

  task automatic check(input string nm, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 4) != 0;
        default: out_ready = rdy_man;
      endcase
    end
  end

  // monitor: compare every presented beat against the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
      if (capture_inst === 1'b1) cap_cnt++;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_beat", {376'd0, out_inst}, 384'hFFFF);
        else begin
          check("v0", out_v0, exp_q[0].v0);
          check("v1", out_v1, exp_q[0].v1);
          check("v2", out_v2, exp_q[0].v2);
          check("xform", out_xform, exp_q[0].xf);
          check("inst", out_inst, exp_q[0].inst);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic set_inst(input int i, input int vb, input int vc, input int tbv, input int tc);
    vb_arr[i] = VA_W'(vb); vc_arr[i] = VIDX_W'(vc);
    tb_arr[i] = TA_W'(tbv); tc_arr[i] = TIDX_W'(tc);
  endtask

  task automatic set_tri(input int a, input int i0, input int i1, input int i2);
    tri_mem[a % 8192] = {VIDX_W'(i0), VIDX_W'(i1), VIDX_W'(i2)};
  endtask

  // reference: every triangle of every instance in order, addresses modulo RAM depth
  task automatic plan_frame(input int n);
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < int'(tc_arr[i]); t++) begin
        logic [3*VIDX_W-1:0] ix;
        int i0, i1, i2, vb, vc;
        beat_t b;
        ix = tri_mem[(int'(tb_arr[i]) + t) % 8192];
        i0 = int'(ix[35:24]); i1 = int'(ix[23:12]); i2 = int'(ix[11:0]);
        vb = int'(vb_arr[i]); vc = int'(vc_arr[i]);
        b.v0 = vdata(VA_W'((vb + i0) % 8192));
        b.v1 = vdata(VA_W'((vb + i1) % 8192));
        b.v2 = vdata(VA_W'((vb + i2) % 8192));
        b.xf = xfdata(IA_W'(i));
        b.inst = IA_W'(i);
        if (i0 >= vc || i1 >= vc || i2 >= vc) exp_err = 1'b1;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    start = 1'b1; num_inst = (IA_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic launch_frame(input int n);
    plan_frame(n);
    fd0 = fd_cnt; cap0 = cap_cnt; exp_n = n;
    pulse_start(n);
  endtask

  task automatic end_frame();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (frame_done !== 1'b1 && k < 5000);
    check("frame_done_seen", frame_done, 1);
    @(posedge clk); #1;
    check("frame_done_cnt", fd_cnt, fd0 + 1);
    check("capture_cnt", cap_cnt, cap0 + exp_n);
    check("idx_err", idx_err, exp_err);
    check("beats_left", exp_q.size(), 0);
    check("busy_after", busy, 0);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (out_valid !== 1'b1 && k < 200);
    check("wait_valid", out_valid, 1);
  endtask

  initial begin
    rst_render = 1'b1; start = 1'b0; abort = 1'b0; mem_ready = 1'b1; num_inst = '0;
    for (int a = 0; a < 8192; a++) tri_mem[a] = '0;
    for (int i = 0; i < 256; i++) set_inst(i, 0, 1, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", idx_err, 0);
    check("rst_cap", capture_inst, 0);
    check("rst_vaddr", vert_addr_rd, 0);
    check("rst_taddr", tri_addr_rd, 0);
    check("rst_iaddr", inst_id_rd, 0);
    @(posedge clk); #1 rst_render = 1'b0;

    // single triangle, vertex address sequence
    set_inst(0, 100, 10, 50, 1);
    set_tri(50, 0, 1, 2);
    launch_frame(1);
    repeat (6) @(posedge clk);
    @(negedge clk); check("vaddr0", vert_addr_rd, 100);
    @(negedge clk); check("vaddr1", vert_addr_rd, 101);
    @(negedge clk); check("vaddr2", vert_addr_rd, 102);
    end_frame();

    // two instances, 3 + 2 triangles, random backpressure
    set_inst(0, 200, 20, 300, 3);
    set_inst(1, 400, 20, 310, 2);
    for (int t = 0; t < 3; t++) set_tri(300 + t, t, t + 3, t + 7);
    for (int t = 0; t < 2; t++) set_tri(310 + t, 19 - t, t, 5);
    rdy_mode = 1;
    launch_frame(2);
    end_frame();

    // stall 10 cycles in OUT
    set_inst(0, 1000, 30, 700, 2);
    set_tri(700, 1, 2, 3);
    set_tri(701, 4, 5, 6);
    rdy_mode = 2; rdy_man = 1'b0;
    launch_frame(1);
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_vaddr", vert_addr_rd, 1003);
      check("stall_taddr", tri_addr_rd, 700);
    end
    rdy_man = 1'b1;
    end_frame();
    rdy_mode = 0;

    // num_inst = 0
    fd0 = fd_cnt;
    pulse_start(0);
    @(negedge clk); check("zero_done", frame_done, 1);
    @(negedge clk); check("zero_idle", busy, 0);
    @(posedge clk); #1 check("zero_done_cnt", fd_cnt, fd0 + 1);

    // empty instance in the middle
    set_inst(0, 10, 8, 900, 1);
    set_inst(1, 20, 8, 910, 0);
    set_inst(2, 30, 8, 920, 2);
    set_tri(900, 7, 6, 5);
    set_tri(920, 0, 1, 2);
    set_tri(921, 3, 4, 5);
    launch_frame(3);
    end_frame();

    // vertex/triangle address wrap and out-of-range index
    set_inst(0, 8190, 10, 8191, 2);
    set_tri(8191, 5, 4095, 1);
    set_tri(0, 0, 9, 9);
    launch_frame(1);
    repeat (6) @(posedge clk);
    @(negedge clk); check("wrap_vaddr", vert_addr_rd, 3);
    end_frame();

    // abort during VRD2
    set_inst(0, 500, 10, 1200, 1);
    set_tri(1200, 2, 3, 4);
    launch_frame(1);
    repeat (8) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk); check("abort_vrd2_vaddr", vert_addr_rd, 504);
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    @(negedge clk); check("abort_vrd2_idle", busy, 0);
    repeat (20) @(posedge clk);
    #1 check("abort_vrd2_nodone", fd_cnt, fd0);

    // abort coincident with a handshake
    set_inst(0, 600, 10, 1300, 2);
    set_tri(1300, 1, 1, 1);
    set_tri(1301, 2, 2, 2);
    rdy_mode = 2; rdy_man = 1'b0;
    launch_frame(1);
    wait_valid();
    @(posedge clk);
    rdy_man = 1'b1;
    #1 abort = 1'b1;
    @(negedge clk); check("abort_out_valid", out_valid, 0);
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    rdy_mode = 0;
    @(negedge clk); check("abort_out_idle", busy, 0);
    repeat (30) @(posedge clk);
    #1 check("abort_out_nodone", fd_cnt, fd0);

    // start without mem_ready
    mem_ready = 1'b0;
    pulse_start(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); check("no_ready_idle", busy, 0);
    end
    mem_ready = 1'b1;

    // randomised frames
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      int n;
      n = 1 + int'($urandom % 4);
      for (int i = 0; i < n; i++) begin
        int vb, vc, tbv, tc;
        vb = int'($urandom % 8192); vc = 1 + int'($urandom % 20);
        tbv = int'($urandom % 8192); tc = int'($urandom % 5);
        set_inst(i, vb, vc, tbv, tc);
        for (int t = 0; t < tc; t++) begin
          int ix [3];
          for (int j = 0; j < 3; j++)
            ix[j] = ($urandom % 8 == 0) ? int'($urandom % 4096) : int'($urandom % vc);
          set_tri(tbv + t, ix[0], ix[1], ix[2]);
        end
      end
      launch_frame(n);
      end_frame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
